credit_pad_serializer: RTL
==========================

CREDIT_PAD_SERIALIZER -- requirements
Module: credit_pad_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 256: width of the word accepted from the core-side resource port.
REQ-002 SHALL have parameter PAD_W, default 16: width of one pad beat; DATA_W SHALL be an integer multiple of PAD_W, giving BEATS = DATA_W/PAD_W.
REQ-003 SHALL have parameter CREDITS, default 4: receiver buffer depth in beats, and the credit count after reset; range 1..255.
REQ-004 SHALL have parameter MSB_FIRST, default 0: 0 = beats sent LS slice first, 1 = beats sent MS slice first.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- rsc_z, in, DATA_W: word from the core.
- rsc_lz, in, 1: core asserts when rsc_z is valid.
- rsc_vz, out, 1: block can accept a word.
- pad_data, out, PAD_W: beat payload, registered.
- pad_valid, out, 1: beat present this cycle, registered.
- pad_last, out, 1: final beat of a word, registered.
- pad_credit, in, 1: one-cycle pulse; the receiver returns one beat credit.
- credit_cnt, out, 8: current credit count.
- busy, out, 1: high when state is SEND.
- cred_ovf, out, 1: sticky error flag.

Function
REQ-006 SHALL implement a two-state FSM: IDLE and SEND.
REQ-007 rsc_vz SHALL be 1 if and only if the state is IDLE; a word is accepted in any cycle where rsc_lz and rsc_vz are both 1.
REQ-008 On acceptance, the block SHALL load rsc_z into a DATA_W shift register, clear the beat counter, and enter SEND at the next edge.
REQ-009 In SEND with credit_cnt not 0, the block SHALL register one beat at that edge:
- pad_valid is 1.
- pad_data is the current LS PAD_W slice (MSB_FIRST=0) or MS PAD_W slice (MSB_FIRST=1).
- The shift register shifts by PAD_W.
- The beat counter increments.
REQ-010 In SEND with credit_cnt equal to 0, the block SHALL register pad_valid=0, hold pad_data, and stall with the shift register and beat counter unchanged.
REQ-011 pad_last SHALL be 1 exactly on the beat emitted with beat counter equal to BEATS-1; at that edge the FSM SHALL return to IDLE.
REQ-012 Latency, with credits available: word accepted in cycle c -> first beat valid in cycle c+2 -> last beat valid in cycle c+1+BEATS -> rsc_vz=1 again in cycle c+1+BEATS.
REQ-013 In any cycle not covered by REQ-009, pad_valid and pad_last SHALL be 0.
REQ-014 Credit counter update per edge: minus 1 if a beat is emitted, plus 1 if pad_credit is 1. A simultaneous emit and return SHALL leave the count unchanged.
REQ-015 credit_cnt SHALL never exceed CREDITS. A pad_credit pulse arriving with the count at CREDITS and no concurrent emit SHALL be dropped and SHALL set cred_ovf.
REQ-016 credit_cnt SHALL never underflow; REQ-010 guarantees no emit at 0. A credit returned while the count is 0 SHALL enable an emit on the following cycle, not the same cycle.
REQ-017 rsc_lz while rsc_vz=0 SHALL be ignored; the held word SHALL NOT be corrupted.
REQ-018 BEATS=1 SHALL be supported: every beat has pad_last=1.

Reset
REQ-019 While rst=1 at an edge, the block SHALL set:
- state to IDLE.
- pad_valid, pad_last and cred_ovf to 0.
- pad_data and the shift register to 0.
- beat counter to 0.
- credit_cnt to CREDITS.
REQ-020 rsc_vz SHALL read 0 while rst is high and 1 in the first cycle after rst falls.
REQ-021 A reset in mid-word SHALL discard the remaining beats with no pad_last emitted; the pad-side receiver is reset by the same rst.
REQ-022 cred_ovf SHALL clear only on reset.

Verification (DATA_W=64, PAD_W=16, CREDITS=2 unless stated)
REQ-023 Basic transfer: pad_credit pulsed each beat, send rsc_z=64'h4444_3333_2222_1111 -> pad_data sequence 1111, 2222, 3333, 4444 in consecutive cycles starting at c+2, with pad_last only on 4444.
REQ-024 MSB_FIRST=1, same word -> pad_data sequence 4444, 3333, 2222, 1111.
REQ-025 Credit stall: no credits returned -> two beats emitted, pad_valid=0, credit_cnt=0; pulse pad_credit once -> exactly one further beat, emitted on the next cycle.
REQ-026 Overflow: pad_credit pulsed at credit_cnt=2 while IDLE -> credit_cnt stays 2 and cred_ovf=1 until rst.
REQ-027 Reset mid-word: rst asserted after the second beat -> next cycle pad_valid=0, credit_cnt=2, rsc_vz=1 after release; rsc_lz held high during SEND causes no second capture.

Source files
------------

// File: rtl/credit_pad_serializer.sv
// Credit-flow serializer: takes one DATA_W word from the core and emits it as
// BEATS pad beats of PAD_W bits, one per cycle, gated by receiver credits.
module credit_pad_serializer #(
  parameter int DATA_W    = 256,
  parameter int PAD_W     = 16,
  parameter int CREDITS   = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rsc_z,
  input  logic              rsc_lz,
  output logic              rsc_vz,
  output logic [PAD_W-1:0]  pad_data,
  output logic              pad_valid,
  output logic              pad_last,
  input  logic              pad_credit,
  output logic [7:0]        credit_cnt,
  output logic              busy,
  output logic              cred_ovf
);

  localparam int BEATS = DATA_W / PAD_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [7:0]     CRED_MAX  = 8'(CREDITS);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state;
  logic [DATA_W-1:0]  shreg;
  logic [BCW-1:0]     beat_cnt;
  logic               emit;
  logic [PAD_W-1:0]   cur_slice;
  logic [DATA_W-1:0]  shreg_nxt;

  // Held low during reset so the core cannot hand over a word that reset drops.
  assign rsc_vz = (state == IDLE) && !rst;
  assign busy   = (state == SEND);
  assign emit   = (state == SEND) && (credit_cnt != 8'd0);

  generate
    if (MSB_FIRST) begin : g_msb
      assign cur_slice = shreg[DATA_W-1 -: PAD_W];
      assign shreg_nxt = shreg << PAD_W;
    end else begin : g_lsb
      assign cur_slice = shreg[PAD_W-1:0];
      assign shreg_nxt = shreg >> PAD_W;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      beat_cnt   <= '0;
      pad_data   <= '0;
      pad_valid  <= 1'b0;
      pad_last   <= 1'b0;
      credit_cnt <= CRED_MAX;
      cred_ovf   <= 1'b0;
    end else begin
      pad_valid <= 1'b0;
      pad_last  <= 1'b0;

      case (state)
        IDLE: begin
          if (rsc_lz) begin
            shreg    <= rsc_z;
            beat_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (emit) begin
            pad_valid <= 1'b1;
            pad_data  <= cur_slice;
            shreg     <= shreg_nxt;
            beat_cnt  <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              pad_last <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A returned credit at the ceiling is only legal when a beat leaves the same cycle.
      case ({emit, pad_credit})
        2'b10: credit_cnt <= credit_cnt - 8'd1;
        2'b01: begin
          if (credit_cnt >= CRED_MAX) cred_ovf   <= 1'b1;
          else                        credit_cnt <= credit_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
